// File: rtl/z80_interrupt_controller_if.sv
// z80_interrupt_controller_if
//   Bus-side signal bundle for the mode-2 interrupt controller.
//   slave  : the controller (consumes the Z80 strobes and device requests,
//            drives read/vector data and /INT).
//   master : the bus controller / CPU side driving the strobes.
//   Signals:
//     i_cs_n, i_rd_n, i_wr_n : register window select and strobes
//     i_m1_n, i_iorq_n       : raw Z80 /M1 and /IORQ for INTA detection
//     i_addr[1:0]            : register select
//     i_data[7:0]            : write data
//     o_data[7:0], o_data_en : read or vector data and its bus enable
//     i_irq[3:0]             : asynchronous device requests, bit 0 highest
//     o_int_n                : registered Z80 /INT
interface z80_interrupt_controller_if;
  logic       i_cs_n;
  logic       i_rd_n;
  logic       i_wr_n;
  logic       i_m1_n;
  logic       i_iorq_n;
  logic [1:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_data_en;
  logic [3:0] i_irq;
  logic       o_int_n;

  modport slave (
    input  i_cs_n, i_rd_n, i_wr_n, i_m1_n, i_iorq_n, i_addr, i_data, i_irq,
    output o_data, o_data_en, o_int_n
  );

  modport master (
    output i_cs_n, i_rd_n, i_wr_n, i_m1_n, i_iorq_n, i_addr, i_data, i_irq,
    input  o_data, o_data_en, o_int_n
  );
endinterface

// File: rtl/z80_interrupt_controller.sv
// z80_interrupt_controller
//   Mode-2 vectored interrupt controller with four prioritised, nestable
//   sources. Drives /INT and supplies the vector byte during INTA.
//   Ports:
//     i_clk   : system clock (inverted bus clock)
//     i_reset : asynchronous active-high reset
//     bus     : z80_interrupt_controller_if.slave (register window, INTA
//               strobes, device requests, data out and /INT)
//   Register map (i_addr):
//     0 CTRL  [3:0] MASK, [7:4] EDGE (1 = rising edge, 0 = level)
//     1 PEND  read {4'b0,PEND}; write-1-to-clear on edge-mode bits
//     2 VBASE vector base, bits [7:4] used
//     3 INSV  read {4'b0,INSV}; any write is EOI (clears lowest set bit)
module z80_interrupt_controller #(
  parameter logic [7:0]  VECTOR_RESET = 8'h00,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic i_clk,
  input logic i_reset,
  z80_interrupt_controller_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0] r_irq_prev;
  logic [3:0] r_mask;
  logic [3:0] r_edge;
  logic [3:0] r_pend;
  logic [3:0] r_insv;
  logic [7:0] r_vbase;
  logic       r_wr_prev;
  logic       r_int_n;
  logic [1:0] r_src;
  logic       r_spur;

  logic [3:0] w_irq_s;
  logic       w_wr;
  logic       w_wr_pulse;
  logic       w_rd;
  logic       w_inta;
  logic       w_ack_start;
  logic [3:0] w_cand;
  logic [3:0] w_insv_low;
  logic [3:0] w_allow;
  logic [3:0] w_elig;
  logic       w_win_any;
  logic [1:0] w_win_idx;
  logic [3:0] w_ack_bit;
  logic [3:0] w_pend_next;
  logic [3:0] w_insv_next;
  logic       w_eoi;
  logic       w_w1c;
  logic [7:0] w_data;

  assign w_irq_s    = r_sync[SYNC_STAGES-1];
  assign w_wr       = ~bus.i_cs_n & ~bus.i_wr_n;
  assign w_wr_pulse = w_wr & ~r_wr_prev;
  assign w_rd       = ~bus.i_cs_n & ~bus.i_rd_n;
  assign w_inta     = ~bus.i_m1_n & ~bus.i_iorq_n;
  assign w_eoi      = w_wr_pulse & (bus.i_addr == 2'd3);
  assign w_w1c      = w_wr_pulse & (bus.i_addr == 2'd1);

  // Arbitration: only sources strictly above the highest-priority in-service
  // level may win; the lowest set INSV bit marks that level.
  always_comb begin
    w_cand     = r_pend & r_mask;
    w_insv_low = r_insv & (~r_insv + 4'd1);
    w_allow    = (r_insv == 4'd0) ? 4'hF : (w_insv_low - 4'd1);
    w_elig     = w_cand & w_allow;
    w_win_any  = |w_elig;
    w_win_idx  = 2'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_elig[3-k]) w_win_idx = 2'(3 - k);
    end
    w_ack_bit  = (w_ack_start & w_win_any) ? (4'b0001 << w_win_idx) : 4'b0000;
  end

  // Acknowledge FSM: ST_ACK spans the whole INTA strobe.
  always_comb begin
    w_state_next = r_state;
    w_ack_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_inta) begin
          w_state_next = ST_ACK;
          w_ack_start  = 1'b1;
        end
      end
      ST_ACK: begin
        if (!w_inta) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pending/in-service next state. Edge bits: a set event beats a
  // same-cycle clear. Level bits simply track the synchronised request.
  always_comb begin
    w_pend_next = r_pend;
    for (int unsigned n = 0; n < 4; n++) begin
      if (r_edge[n]) begin
        w_pend_next[n] = (w_irq_s[n] & ~r_irq_prev[n]) |
                         (r_pend[n] & ~((w_w1c & bus.i_data[n]) | w_ack_bit[n]));
      end else begin
        w_pend_next[n] = w_irq_s[n];
      end
    end
    w_insv_next = (w_eoi ? (r_insv & (r_insv - 4'd1)) : r_insv) | w_ack_bit;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_sync     <= '0;
      r_irq_prev <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_pend     <= '0;
      r_insv     <= '0;
      r_vbase    <= VECTOR_RESET;
      r_wr_prev  <= 1'b0;
      r_int_n    <= 1'b1;
      r_src      <= '0;
      r_spur     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.i_irq};
      r_irq_prev <= w_irq_s;
      r_wr_prev  <= w_wr;
      r_pend     <= w_pend_next;
      r_insv     <= w_insv_next;
      r_int_n    <= ~(w_win_any & (r_state == ST_IDLE) & ~w_ack_start);
      if (w_ack_start) begin
        r_src  <= w_win_any ? w_win_idx : 2'd0;
        r_spur <= ~w_win_any;
      end
      if (w_wr_pulse && bus.i_addr == 2'd0) {r_edge, r_mask} <= bus.i_data;
      if (w_wr_pulse && bus.i_addr == 2'd2) r_vbase <= bus.i_data;
    end
  end

  // The vector is shown live on the first INTA cycle and frozen from the
  // capture edge onward, so the CPU sees a stable byte for the whole strobe.
  always_comb begin
    w_data = 8'h00;
    if (w_inta) begin
      if (r_state == ST_ACK)
        w_data = {r_vbase[7:4], r_spur, r_src, 1'b0};
      else
        w_data = {r_vbase[7:4], ~w_win_any, (w_win_any ? w_win_idx : 2'd0), 1'b0};
    end else if (w_rd) begin
      case (bus.i_addr)
        2'd0:    w_data = {r_edge, r_mask};
        2'd1:    w_data = {4'h0, r_pend};
        2'd2:    w_data = r_vbase;
        default: w_data = {4'h0, r_insv};
      endcase
    end
  end

  assign bus.o_data    = i_reset ? 8'h00 : w_data;
  assign bus.o_data_en = ~i_reset & (w_inta | w_rd);
  assign bus.o_int_n   = r_int_n;

endmodule

// File: tb/tb_z80_interrupt_controller.sv
// tb_z80_interrupt_controller
//   Directed bench for z80_interrupt_controller. Stimulus pushes expected
//   bus/INT values into a queue; the monitor pops and compares them on each
//   falling clock edge, or on ev_sample while the clock is stopped.
module tb_z80_interrupt_controller;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic r_clk_run = 1'b1;

  z80_interrupt_controller_if bus_if();

  z80_interrupt_controller #(
    .VECTOR_RESET(8'h00),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus_if.slave)
  );

  always #5 if (r_clk_run) i_clk = ~i_clk;

  typedef struct {
    string      name;
    bit         is_int;
    logic [8:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  event ev_sample;

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge i_clk or ev_sample);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = e.is_int ? {8'h00, bus_if.o_int_n} : {bus_if.o_data_en, bus_if.o_data};
        n_vec++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    #1;
  endtask

  task automatic sample_now();
    -> ev_sample;
    #1;
  endtask

  task automatic expect_bus(input string name, input logic [7:0] v);
    exp_t e;
    e.name = name; e.is_int = 1'b0; e.val = {1'b1, v};
    q.push_back(e);
  endtask

  task automatic expect_idle(input string name);
    exp_t e;
    e.name = name; e.is_int = 1'b0; e.val = 9'h000;
    q.push_back(e);
  endtask

  task automatic expect_int(input string name, input logic v);
    exp_t e;
    e.name = name; e.is_int = 1'b1; e.val = {8'h00, v};
    q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int unsigned hold = 1);
    bus_if.i_cs_n = 1'b0; bus_if.i_wr_n = 1'b0;
    bus_if.i_addr = a;    bus_if.i_data = d;
    tick(hold);
    bus_if.i_cs_n = 1'b1; bus_if.i_wr_n = 1'b1;
    tick();
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] v);
    bus_if.i_cs_n = 1'b0; bus_if.i_rd_n = 1'b0; bus_if.i_addr = a;
    expect_bus(name, v);
    sample();
    bus_if.i_cs_n = 1'b1; bus_if.i_rd_n = 1'b1;
  endtask

  task automatic inta_on();
    bus_if.i_m1_n = 1'b0; bus_if.i_iorq_n = 1'b0;
  endtask

  task automatic inta_off();
    bus_if.i_m1_n = 1'b1; bus_if.i_iorq_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    bus_if.i_cs_n = 1'b1; bus_if.i_rd_n = 1'b1; bus_if.i_wr_n = 1'b1;
    bus_if.i_m1_n = 1'b1; bus_if.i_iorq_n = 1'b1;
    bus_if.i_addr = 2'd0; bus_if.i_data = 8'h00; bus_if.i_irq = 4'h0;

    // Reset: a read during reset must not drive the bus.
    tick(2);
    bus_if.i_cs_n = 1'b0; bus_if.i_rd_n = 1'b0;
    expect_int("rst_int_n", 1'b1);
    expect_idle("rst_bus_idle");
    sample();
    bus_if.i_cs_n = 1'b1; bus_if.i_rd_n = 1'b1;
    i_reset = 1'b0;
    tick();
    rd("rst_ctrl", 2'd0, 8'h00);
    rd("rst_pend", 2'd1, 8'h00);
    rd("rst_vbase", 2'd2, 8'h00);
    rd("rst_insv", 2'd3, 8'h00);

    // 1: edge source 0, latency and vector.
    wr(2'd0, 8'h11);
    wr(2'd2, 8'h40);
    rd("t1_ctrl", 2'd0, 8'h11);
    rd("t1_vbase", 2'd2, 8'h40);
    tick();
    bus_if.i_irq[0] = 1'b1;
    tick();
    bus_if.i_irq[0] = 1'b0;
    tick(2);
    expect_int("t1_lat3_high", 1'b1);
    sample();
    tick();
    expect_int("t1_lat4_low", 1'b0);
    sample();
    inta_on();
    expect_bus("t1_vec_live", 8'h40);
    sample();
    tick();
    expect_bus("t1_vec_frozen", 8'h40);
    expect_int("t1_int_in_ack", 1'b1);
    sample();
    inta_off();
    rd("t1_insv", 2'd3, 8'h01);
    rd("t1_pend", 2'd1, 8'h00);
    tick();
    expect_int("t1_int_after", 1'b1);
    sample();
    wr(2'd3, 8'h00);
    rd("t1_insv_eoi", 2'd3, 8'h00);

    // 2: level sources 1 and 2 together; 1 wins, 2 waits for EOI.
    wr(2'd0, 8'h06);
    bus_if.i_irq = 4'b0110;
    tick(5);
    expect_int("t2_int", 1'b0);
    sample();
    inta_on();
    expect_bus("t2_vec_src1", 8'h42);
    sample();
    tick();
    inta_off();
    bus_if.i_irq[1] = 1'b0;
    tick(4);
    expect_int("t2_no_int_src2", 1'b1);
    sample();
    rd("t2_insv", 2'd3, 8'h02);
    wr(2'd3, 8'h00);
    tick(2);
    expect_int("t2_int_src2", 1'b0);
    sample();
    inta_on();
    expect_bus("t2_vec_src2", 8'h44);
    sample();
    tick();
    inta_off();
    tick(2);
    expect_int("t2_src2_busy", 1'b1);
    sample();
    rd("t2_insv2", 2'd3, 8'h04);

    // 3: nesting source 0 over in-service source 2; held EOI clears one bit.
    wr(2'd0, 8'h17);
    bus_if.i_irq[0] = 1'b1;
    tick(5);
    expect_int("t3_nest_int", 1'b0);
    sample();
    inta_on();
    expect_bus("t3_vec", 8'h40);
    sample();
    tick();
    inta_off();
    rd("t3_insv", 2'd3, 8'h05);
    wr(2'd3, 8'h00, 3);
    rd("t3_insv_eoi", 2'd3, 8'h04);
    tick();
    expect_int("t3_int_after_eoi", 1'b1);
    sample();
    bus_if.i_irq = 4'h0;
    wr(2'd3, 8'h00);
    rd("t3_insv_clr", 2'd3, 8'h00);
    wr(2'd3, 8'h00);
    rd("t3_eoi_noop", 2'd3, 8'h00);
    tick(4);
    rd("t3_pend_clr", 2'd1, 8'h00);

    // 4: mask removed just before INTA is captured -> spurious vector.
    wr(2'd0, 8'h11);
    bus_if.i_irq[0] = 1'b1;
    tick();
    bus_if.i_irq[0] = 1'b0;
    tick(4);
    expect_int("t4_int", 1'b0);
    sample();
    bus_if.i_cs_n = 1'b0; bus_if.i_wr_n = 1'b0;
    bus_if.i_addr = 2'd0; bus_if.i_data = 8'h10;
    tick();
    bus_if.i_cs_n = 1'b1; bus_if.i_wr_n = 1'b1;
    inta_on();
    expect_bus("t4_vec_live", 8'h48);
    sample();
    tick();
    expect_bus("t4_vec_frozen", 8'h48);
    sample();
    inta_off();
    rd("t4_insv", 2'd3, 8'h00);
    rd("t4_pend_kept", 2'd1, 8'h01);
    tick();
    expect_int("t4_int_idle", 1'b1);
    sample();
    wr(2'd1, 8'h01);
    rd("t4_pend_w1c", 2'd1, 8'h00);

    // 5: W1C racing a new edge, plain W1C, W1C on a level bit.
    wr(2'd0, 8'h80);
    bus_if.i_irq[3] = 1'b1;
    tick();
    bus_if.i_irq[3] = 1'b0;
    tick(4);
    rd("t5_pend_set", 2'd1, 8'h08);
    tick();
    bus_if.i_irq[3] = 1'b1;
    tick();
    bus_if.i_irq[3] = 1'b0;
    tick();
    bus_if.i_cs_n = 1'b0; bus_if.i_wr_n = 1'b0;
    bus_if.i_addr = 2'd1; bus_if.i_data = 8'h08;
    tick();
    bus_if.i_cs_n = 1'b1; bus_if.i_wr_n = 1'b1;
    tick();
    rd("t5_pend_race", 2'd1, 8'h08);
    wr(2'd1, 8'h08);
    rd("t5_pend_w1c", 2'd1, 8'h00);
    bus_if.i_irq[2] = 1'b1;
    tick(4);
    rd("t5_pend_lvl", 2'd1, 8'h04);
    wr(2'd1, 8'h04);
    rd("t5_pend_lvl_w1c", 2'd1, 8'h04);
    bus_if.i_irq = 4'h0;
    tick(4);
    rd("t5_pend_lvl_drop", 2'd1, 8'h00);

    // 6: asynchronous reset in the middle of INTA with the clock stopped.
    wr(2'd0, 8'h11);
    wr(2'd2, 8'h40);
    bus_if.i_irq[0] = 1'b1;
    tick();
    bus_if.i_irq[0] = 1'b0;
    tick(5);
    expect_int("t6_int", 1'b0);
    sample();
    inta_on();
    tick();
    expect_bus("t6_vec", 8'h40);
    sample();
    r_clk_run = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    expect_idle("t6_rst_bus_idle");
    expect_int("t6_rst_int_n", 1'b1);
    sample_now();
    n_vec++;
    if (bus_if.o_data_en !== 1'b0) begin
      n_err++;
      $display("FAIL t6_rst_en_direct: got %b expected 0", bus_if.o_data_en);
    end
    n_vec++;
    if (bus_if.o_int_n !== 1'b1) begin
      n_err++;
      $display("FAIL t6_rst_int_direct: got %b expected 1", bus_if.o_int_n);
    end
    n_vec++;
    if (bus_if.o_data !== 8'h00) begin
      n_err++;
      $display("FAIL t6_rst_data_direct: got %h expected 00", bus_if.o_data);
    end
    bus_if.i_m1_n = 1'b1; bus_if.i_iorq_n = 1'b1;
    i_reset = 1'b0;
    #1;
    bus_if.i_cs_n = 1'b0; bus_if.i_rd_n = 1'b0;
    bus_if.i_addr = 2'd0;
    #1;
    expect_bus("t6_ctrl", 8'h00);
    sample_now();
    bus_if.i_addr = 2'd1;
    #1;
    expect_bus("t6_pend", 8'h00);
    sample_now();
    bus_if.i_addr = 2'd2;
    #1;
    expect_bus("t6_vbase", 8'h00);
    sample_now();
    bus_if.i_addr = 2'd3;
    #1;
    expect_bus("t6_insv", 8'h00);
    expect_int("t6_int_n_after", 1'b1);
    sample_now();
    bus_if.i_cs_n = 1'b1; bus_if.i_rd_n = 1'b1;
    r_clk_run = 1'b1;
    tick(2);
    sample();

    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: got %0d expected 0", q.size());
    end
    if (n_vec < 12) begin
      n_err++;
      $display("FAIL vector_count: got %0d expected at least 12", n_vec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z80_interrupt_controller.md
Name: z80_interrupt_controller

Overview:
- Mode-2 vectored interrupt controller for the Z80 bus controller; sits directly upstream of the core's `o_int_n` output and its read-data mux.
- Collects up to four device interrupt requests (UART A/B, expansion slots) and prioritises them with nesting.
- Drives `/INT` and supplies the mode-2 vector byte during the Z80 interrupt-acknowledge cycle.
- Programmed through a 4-register I/O window decoded by the bus controller.

Parameters:
- `VECTOR_RESET`, 8'h00, reset value of the vector base register.
- `SYNC_STAGES`, 2, synchroniser depth on `i_irq`; legal values 2..3.

Ports:
- `i_clk`  in  1  system clock. Inverted bus clock, as for the MMU.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_cs_n`  in  1  register window select, already qualified with IORQ and M1.
- `i_rd_n`  in  1  Z80 /RD.
- `i_wr_n`  in  1  Z80 /WR.
- `i_m1_n`  in  1  Z80 /M1, raw.
- `i_iorq_n`  in  1  Z80 /IORQ, raw. Used for INTA detection.
- `i_addr`  in  2  register select (A1:A0).
- `i_data`  in  8  write data.
- `o_data`  out  8  read or vector data.
- `o_data_en`  out  1  high when `o_data` must be driven onto the bus.
- `i_irq`  in  4  device requests, active-high, asynchronous. Bit 0 has the highest priority.
- `o_int_n`  out  1  Z80 /INT, registered, active-low.

Behaviour:
- **Reset.** Clock is `i_clk`; reset is asynchronous active-high `i_reset`. Reset clears the following immediately, including mid-INTA or mid-write:
  - `MASK`, `EDGE`, `PEND`, `INSV`, `ack_active` = 0.
  - `VBASE` = `VECTOR_RESET`.
  - `o_int_n` = 1, `o_data_en` = 0, `o_data` = 8'h00.
- **Register map.**
  - addr 0: `CTRL`. [3:0] `MASK` enables; [7:4] `EDGE` select (1 = rising-edge, 0 = level). Read/write.
  - addr 1: `PEND`. Read returns {4'b0, `PEND`}. Write-1-to-clear, edge-mode bits only.
  - addr 2: `VBASE`. Read/write; only bits [7:4] are used in the vector.
  - addr 3: `INSV`. Read returns {4'b0, `INSV`}. Any write is EOI: clears the lowest-numbered set `INSV` bit. EOI with `INSV` = 0 is a no-op.
- **Writes.** Take effect once per strobe, on the first `i_clk` edge where `~i_cs_n & ~i_wr_n` is seen and was not seen the previous cycle.
- **Reads.** Combinational. `o_data_en` = `~i_cs_n & ~i_rd_n`. `o_data` = the selected register, else 8'h00.
- **Request path.**
  - `i_irq` passes through `SYNC_STAGES` flops to give `irq_s`.
  - Edge mode: `PEND[n]` sets when `irq_s[n]` is 1 and was 0 the previous cycle. It clears by write-1-to-clear or by acknowledge.
  - Level mode: `PEND[n]` is registered `irq_s[n]` every cycle and ignores W1C.
  - If a set event and a clear event occur in the same cycle, set wins.
- **Arbitration.**
  - `cand` = `PEND & MASK`.
  - `win` = lowest-numbered set bit of `cand` whose index is lower than the lowest set `INSV` bit; any set bit qualifies if `INSV` = 0.
  - `o_int_n` is registered: 0 iff `win` exists and `ack_active` = 0.
  - Latency from `i_irq` rise to `o_int_n` low is `SYNC_STAGES` + 2 cycles.
- **Acknowledge.** INTA = `~i_m1_n & ~i_iorq_n`.
  - On the first clock with INTA (with `ack_active` = 0), set `ack_active` and capture:
    - `src` = `win`, `spur` = 0, or `spur` = 1 and `src` = 0 if no `win`.
    - Set `INSV[src]` and clear edge-mode `PEND[src]`, both only if not `spur`.
  - While INTA is asserted: `o_data_en` = 1 and `o_data` = {`VBASE[7:4]`, `spur`, `src[1:0]`, 1'b0}. The vector is frozen and the register read path is overridden.
  - `ack_active` clears on the first clock with INTA deasserted.
  - `o_int_n` is forced high while `ack_active` = 1, then re-evaluated against the new `INSV`.
- **Nesting.**
  - A higher-priority source can interrupt a lower in-service one.
  - A same- or lower-priority source waits for EOI.
  - A level source still asserted after EOI re-requests.
- **Masking.** Masking a source does not clear `PEND` or `INSV`.

Test Plan:
1. Reset, `CTRL`=8'h11, `VBASE`=8'h40; pulse `i_irq[0]` for 1 cycle -> `o_int_n` low 4 cycles later; INTA -> `o_data`=8'h40, `o_data_en`=1; `INSV` reads 8'h01, `PEND` reads 8'h00, `o_int_n` high.
2. Level mode, `CTRL`=8'h06, raise `i_irq[1]` and `i_irq[2]` together -> vector `src`=1 (8'h42 with `VBASE` 8'h40). After INTA, no `/INT` for src 2. EOI -> `/INT` for src 2, vector 8'h44.
3. Nesting: src 2 in service, raise `i_irq[0]` (enabled) -> `/INT` asserts, vector 8'h40, `INSV`=8'h05. First EOI clears bit 0 only, giving `INSV`=8'h04.
4. Spurious: pending source masked via `CTRL` write in the same cycle INTA begins -> vector 8'h48 (`VBASE` 8'h40), `INSV` unchanged.
5. W1C race: edge src 3 pending, write `PEND`=8'h08 on the same cycle as a new sync'd edge -> `PEND[3]` stays 1. A W1C without an edge clears it. W1C on a level bit has no effect.
6. Assert `i_reset` during an INTA with `o_data_en`=1 -> `o_data_en`=0, `o_int_n`=1, all registers at reset values immediately, no clock required.
